axi_errslave: RTL and testbench
===============================

AXI_ERRSLAVE -- requirements
Module: axi_errslave

Interface
REQ-001 SHALL provide parameter C_AXI_ID_WIDTH, default 2, ID width of all ID ports.
REQ-002 SHALL provide parameter C_AXI_DATA_WIDTH, default 32, RDATA width (power of 2, 8..1024).
REQ-003 SHALL provide parameter OPT_RESP, default 2'b11, response code on every B and R beat (2'b10 SLVERR or 2'b11 DECERR only).
REQ-004 SHALL provide parameter OPT_RDATA, default all-zero, C_AXI_DATA_WIDTH-bit constant driven on RDATA.
REQ-005 SHALL provide parameter LGBFIFO, default 2, log2 depth of the write-response ID queue (1..6).
REQ-006 SHALL provide parameter CW, default 16, width of the error counters.
REQ-007 Ports: S_AXI_ACLK  in  1  clock; S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
REQ-008 S_AXI_AWVALID in 1, S_AXI_AWREADY out 1, S_AXI_AWID in IW: write address handshake.
REQ-009 S_AXI_WVALID in 1, S_AXI_WREADY out 1, S_AXI_WLAST in 1: write data handshake (data/strobe not needed).
REQ-010 S_AXI_BVALID out 1, S_AXI_BREADY in 1, S_AXI_BID out IW, S_AXI_BRESP out 2: write response.
REQ-011 S_AXI_ARVALID in 1, S_AXI_ARREADY out 1, S_AXI_ARID in IW, S_AXI_ARLEN in 8: read address.
REQ-012 S_AXI_RVALID out 1, S_AXI_RREADY in 1, S_AXI_RID out IW, S_AXI_RDATA out DW, S_AXI_RLAST out 1, S_AXI_RRESP out 2: read data.
REQ-013 i_clear in 1 (sync counter clear); o_wr_errs out CW; o_rd_errs out CW (burst error counts).

Function
REQ-014 AW and W SHALL each pass through a skid buffer; AWREADY/WREADY are the skid buffers' ready outputs.
REQ-015 Non-last W beats SHALL be consumed from the W skid buffer every cycle they are valid, independent of AW.
REQ-016 A write burst SHALL complete in the cycle that buffered AW valid, buffered W valid with WLAST, and B queue not full (or full with a B handshake in the same cycle); both are popped and AWID pushed.
REQ-017 B queue SHALL be a 2^LGBFIFO-entry FIFO; BVALID = queue non-empty, BID = head entry, BRESP = OPT_RESP.
REQ-018 First BVALID SHALL rise the cycle after a completing push into an empty queue; B order equals AW order.
REQ-019 Queue full with no BREADY: last W beat and AW SHALL be held in skid buffers; no loss, no duplicates.
REQ-020 Read engine SHALL have two states: IDLE (ARREADY=1, RVALID=0) and BURST (RVALID=1).
REQ-021 AR handshake SHALL load beat counter with ARLEN+1 (9-bit), latch ARID, enter BURST; first RVALID next cycle.
REQ-022 Each R handshake SHALL decrement the counter; RLAST = 1 exactly when counter == 1.
REQ-023 ARREADY SHALL also be 1 in BURST when RLAST && RREADY, so back-to-back bursts run without a bubble; otherwise BURST with no new AR returns to IDLE after the last beat.
REQ-024 RDATA = OPT_RDATA, RRESP = OPT_RESP, RID constant for the whole burst.
REQ-025 o_wr_errs SHALL increment per B handshake, o_rd_errs per R handshake with RLAST; both saturate at all-ones.
REQ-026 i_clear SHALL zero both counters next edge, with priority over a simultaneous increment.
REQ-027 ARLEN=255 SHALL produce exactly 256 beats (no counter wrap).

Reset
REQ-028 ARESETN low SHALL asynchronously force: BVALID=0, RVALID=0, RLAST=0, ARREADY=1, queue empty, skid buffers empty, read state IDLE, counters 0.
REQ-029 Reset mid-burst SHALL abandon all in-flight transactions; no response for them after release.
REQ-030 ID/data registers need no reset; outputs SHALL be deterministic once valid.

Structure
REQ-031 Shared package SHALL hold response codes (OKAY, SLVERR, DECERR) and the read-state encoding.
REQ-032 Existing skidbuffer SHALL be instantiated twice (AW: IW bits, W: 1 bit, unregistered outputs); B queue is inline.

Verification
REQ-033 Single write AWLEN=0, AWID=2, BREADY=1 -> one B beat, BID=2, BRESP=OPT_RESP, o_wr_errs=1.
REQ-034 LGBFIFO=2, five AWLEN=3 writes (IDs 0..3,1), BREADY=0 -> four queued, fifth held; BREADY=1 -> BIDs 0,1,2,3,1 in order.
REQ-035 AR ARLEN=3 ARID=1, then ARLEN=0 ARID=3 presented during it, RREADY=1 -> 5 contiguous beats, RLAST on beats 4 and 5, RIDs 1,1,1,1,3.
REQ-036 ARLEN=255 with RREADY toggling every cycle -> exactly 256 beats, RLAST only on beat 256, o_rd_errs=1.
REQ-037 Reset asserted mid read burst (beat 2 of 8) -> RVALID=0, ARREADY=1 immediately, no further beats after release.
REQ-038 CW=4, 17 reads -> o_rd_errs saturates at 15; i_clear with concurrent RLAST handshake -> 0.

Source files
------------

// File: rtl/axi_errslave_pkg.sv
// Shared definitions for the AXI error slave: AXI response codes and the
// read-engine state encoding.
package axi_errslave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi_errslave_skid.sv
// Single-entry skid buffer with pass-through (unregistered) outputs; an
// incoming beat is parked only when the consumer stalls.
module axi_errslave_skid
    import axi_errslave_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data
);

    logic          valid_r;
    logic [DW-1:0] data_r;

    // Occupancy: park an accepted beat the consumer did not take, release on ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
        end else if (i_valid && !valid_r && !i_ready) begin
            valid_r <= 1'b1;
        end else if (i_ready) begin
            valid_r <= 1'b0;
        end
    end

    // Payload capture while the buffer is empty; contents matter only when valid_r
    always_ff @(posedge clk) begin
        if (!valid_r) begin
            data_r <= i_data;
        end
    end

    assign o_ready = !valid_r;
    assign o_valid = i_valid || valid_r;
    assign o_data  = valid_r ? data_r : i_data;

endmodule

// File: rtl/axi_errslave.sv
// AXI slave that answers every write and read burst with an error response,
// keeping saturating counts of the erroneous write and read bursts.
module axi_errslave
    import axi_errslave_pkg::*;
#(
    parameter int                          C_AXI_ID_WIDTH   = 2,
    parameter int                          C_AXI_DATA_WIDTH = 32,
    parameter logic [1:0]                  OPT_RESP         = RESP_DECERR,
    parameter logic [C_AXI_DATA_WIDTH-1:0] OPT_RDATA        = {C_AXI_DATA_WIDTH{1'b0}},
    parameter int                          LGBFIFO          = 2,
    parameter int                          CW               = 16
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESETN,

    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]   S_AXI_AWID,

    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,
    input  logic                        S_AXI_WLAST,

    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    output logic [C_AXI_ID_WIDTH-1:0]   S_AXI_BID,
    output logic [1:0]                  S_AXI_BRESP,

    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [7:0]                  S_AXI_ARLEN,

    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY,
    output logic [C_AXI_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [C_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic                        S_AXI_RLAST,
    output logic [1:0]                  S_AXI_RRESP,

    input  logic                        i_clear,
    output logic [CW-1:0]               o_wr_errs,
    output logic [CW-1:0]               o_rd_errs
);

    localparam int                 IW       = C_AXI_ID_WIDTH;
    localparam int                 BDEPTH   = 1 << LGBFIFO;
    localparam logic [LGBFIFO:0]   BDEPTH_W = (LGBFIFO + 1)'(BDEPTH);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1'b1);
    endfunction

    // ------------------------------------------------------------------
    // Write path: AW and W skid buffers feeding the B-ID queue
    // ------------------------------------------------------------------
    logic          awv_s;
    logic [IW-1:0] awid_s;
    logic          aw_pop_s;
    logic          wv_s;
    logic          wlast_s;
    logic          w_pop_s;

    logic [IW-1:0]  bq_mem_r [0:BDEPTH-1];
    logic [LGBFIFO:0] bq_wptr_r;
    logic [LGBFIFO:0] bq_rptr_r;
    logic [LGBFIFO:0] bq_fill_s;
    logic           bq_full_s;
    logic           bq_empty_s;
    logic           b_hs_s;
    logic           wr_done_s;

    axi_errslave_skid #(.DW(IW)) u_aw_skid (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .i_valid (S_AXI_AWVALID),
        .o_ready (S_AXI_AWREADY),
        .i_data  (S_AXI_AWID),
        .o_valid (awv_s),
        .i_ready (aw_pop_s),
        .o_data  (awid_s)
    );

    axi_errslave_skid #(.DW(1)) u_w_skid (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .i_valid (S_AXI_WVALID),
        .o_ready (S_AXI_WREADY),
        .i_data  (S_AXI_WLAST),
        .o_valid (wv_s),
        .i_ready (w_pop_s),
        .o_data  (wlast_s)
    );

    assign bq_fill_s  = bq_wptr_r - bq_rptr_r;
    assign bq_full_s  = (bq_fill_s == BDEPTH_W);
    assign bq_empty_s = (bq_wptr_r == bq_rptr_r);
    assign b_hs_s     = S_AXI_BVALID && S_AXI_BREADY;

    // A full queue still accepts a completion when its head leaves this cycle
    assign wr_done_s = awv_s && wv_s && wlast_s && (!bq_full_s || b_hs_s);
    assign aw_pop_s  = wr_done_s;
    assign w_pop_s   = wv_s && (!wlast_s || wr_done_s);

    // B queue pointers
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            bq_wptr_r <= {(LGBFIFO + 1){1'b0}};
            bq_rptr_r <= {(LGBFIFO + 1){1'b0}};
        end else begin
            if (wr_done_s) begin
                bq_wptr_r <= bq_wptr_r + (LGBFIFO + 1)'(1'b1);
            end
            if (b_hs_s) begin
                bq_rptr_r <= bq_rptr_r + (LGBFIFO + 1)'(1'b1);
            end
        end
    end

    // B queue storage of completed AW IDs
    always_ff @(posedge S_AXI_ACLK) begin
        if (wr_done_s) begin
            bq_mem_r[bq_wptr_r[LGBFIFO-1:0]] <= awid_s;
        end
    end

    assign S_AXI_BVALID = !bq_empty_s;
    assign S_AXI_BID    = bq_mem_r[bq_rptr_r[LGBFIFO-1:0]];
    assign S_AXI_BRESP  = OPT_RESP;

    // ------------------------------------------------------------------
    // Read path: two-state burst engine
    // ------------------------------------------------------------------
    rd_state_t     rd_state_r;
    logic [8:0]    rd_cnt_r;
    logic [IW-1:0] rd_id_r;
    logic          ar_hs_s;
    logic          r_hs_s;

    assign S_AXI_RVALID  = (rd_state_r == RD_BURST);
    assign S_AXI_RLAST   = (rd_state_r == RD_BURST) && (rd_cnt_r == 9'd1);
    assign S_AXI_ARREADY = (rd_state_r == RD_IDLE) || (S_AXI_RLAST && S_AXI_RREADY);
    assign S_AXI_RID     = rd_id_r;
    assign S_AXI_RDATA   = OPT_RDATA;
    assign S_AXI_RRESP   = OPT_RESP;
    assign ar_hs_s       = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs_s        = S_AXI_RVALID && S_AXI_RREADY;

    // Read FSM; the 9-bit counter lets ARLEN=255 run a full 256 beats
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state_r <= RD_IDLE;
            rd_cnt_r   <= 9'd0;
            rd_id_r    <= {IW{1'b0}};
        end else begin
            case (rd_state_r)
                RD_IDLE: begin
                    if (ar_hs_s) begin
                        rd_cnt_r   <= {1'b0, S_AXI_ARLEN} + 9'd1;
                        rd_id_r    <= S_AXI_ARID;
                        rd_state_r <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (ar_hs_s) begin
                        rd_cnt_r   <= {1'b0, S_AXI_ARLEN} + 9'd1;
                        rd_id_r    <= S_AXI_ARID;
                        rd_state_r <= RD_BURST;
                    end else if (r_hs_s) begin
                        rd_cnt_r <= rd_cnt_r - 9'd1;
                        if (rd_cnt_r == 9'd1) begin
                            rd_state_r <= RD_IDLE;
                        end
                    end
                end
                default: begin
                    rd_state_r <= RD_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating error counters; clear wins over a same-cycle increment
    // ------------------------------------------------------------------
    logic [CW-1:0] wr_errs_r;
    logic [CW-1:0] rd_errs_r;

    // Burst error counters
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_errs_r <= {CW{1'b0}};
            rd_errs_r <= {CW{1'b0}};
        end else if (i_clear) begin
            wr_errs_r <= {CW{1'b0}};
            rd_errs_r <= {CW{1'b0}};
        end else begin
            if (b_hs_s) begin
                wr_errs_r <= sat_inc(wr_errs_r);
            end
            if (r_hs_s && S_AXI_RLAST) begin
                rd_errs_r <= sat_inc(rd_errs_r);
            end
        end
    end

    assign o_wr_errs = wr_errs_r;
    assign o_rd_errs = rd_errs_r;

endmodule

// File: tb/tb_axi_errslave.sv
// Randomized scoreboard bench for axi_errslave: stimulus tasks queue the
// expected B/R beats, a negedge monitor pops and compares them.
module tb_axi_errslave;

    localparam int             IW     = 2;
    localparam int             DW     = 32;
    localparam int             CW     = 4;
    localparam logic [1:0]     RESP   = 2'b10;
    localparam logic [DW-1:0]  RDATA  = 32'hDEAD_BEEF;
    localparam int             BUDGET = 3000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          awvalid, awready, wvalid, wready, wlast;
    logic [IW-1:0] awid;
    logic          bvalid, bready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          arvalid, arready;
    logic [IW-1:0] arid;
    logic [7:0]    arlen;
    logic          rvalid, rready, rlast;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          clr;
    logic [CW-1:0] wr_errs, rd_errs;

    typedef struct packed {
        logic [IW-1:0] id;
        logic          last;
    } rbeat_t;

    logic [IW-1:0] exp_b_q [$];
    rbeat_t        exp_r_q [$];
    int            r_cyc_q [$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            wdone, rdone;

    axi_errslave #(
        .C_AXI_ID_WIDTH(IW), .C_AXI_DATA_WIDTH(DW), .OPT_RESP(RESP),
        .OPT_RDATA(RDATA), .LGBFIFO(2), .CW(CW)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWID(awid),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WLAST(wlast),
        .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARID(arid), .S_AXI_ARLEN(arlen),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata),
        .S_AXI_RLAST(rlast), .S_AXI_RRESP(rresp),
        .i_clear(clr), .o_wr_errs(wr_errs), .o_rd_errs(rd_errs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    // Monitor: every B or R handshake is compared against the scoreboard
    always @(negedge clk) begin
        logic [IW-1:0] eb;
        rbeat_t        er;
        if (rst_n) begin
            if (bvalid && bready) begin
                if (exp_b_q.size() == 0) begin
                    check("b_unexpected", 64'd1, 64'd0);
                end else begin
                    eb = exp_b_q.pop_front();
                    check("bid", bid, eb);
                    check("bresp", bresp, RESP);
                end
            end
            if (rvalid && rready) begin
                r_cyc_q.push_back(cyc);
                if (exp_r_q.size() == 0) begin
                    check("r_unexpected", 64'd1, 64'd0);
                end else begin
                    er = exp_r_q.pop_front();
                    check("rid", rid, er.id);
                    check("rlast", rlast, er.last);
                    check("rdata", rdata, RDATA);
                    check("rresp", rresp, RESP);
                end
            end
        end
    end

    task automatic send_aw(input logic [IW-1:0] id);
        bit hs = 1'b0;
        int n = 0;
        awvalid = 1'b1;
        awid    = id;
        while (!hs && n < BUDGET) begin
            @(negedge clk);
            hs = awready;
            if (hs) exp_b_q.push_back(id);
            @(posedge clk); #1;
            n++;
        end
        if (!hs) check("aw_timeout", 64'd0, 64'd1);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            bit hs = 1'b0;
            int n = 0;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            wvalid = 1'b1;
            wlast  = (i == nbeats - 1);
            while (!hs && n < BUDGET) begin
                @(negedge clk);
                hs = wready;
                @(posedge clk); #1;
                n++;
            end
            if (!hs) check("w_timeout", 64'd0, 64'd1);
            wvalid = 1'b0;
            wlast  = 1'b0;
        end
    endtask

    task automatic do_write(input logic [IW-1:0] id, input int nbeats);
        fork
            send_aw(id);
            send_w(nbeats);
        join
    endtask

    task automatic send_ar(input logic [IW-1:0] id, input int len);
        bit hs = 1'b0;
        int n = 0;
        arvalid = 1'b1;
        arid    = id;
        arlen   = 8'(len);
        while (!hs && n < BUDGET) begin
            @(negedge clk);
            hs = arready;
            if (hs) begin
                for (int b = 0; b <= len; b++) begin
                    exp_r_q.push_back('{id: id, last: (b == len)});
                end
            end
            @(posedge clk); #1;
            n++;
        end
        if (!hs) check("ar_timeout", 64'd0, 64'd1);
        arvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        bready = 1'b1;
        rready = 1'b1;
        while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drain"}, 64'(exp_b_q.size() + exp_r_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [IW-1:0] ids [5];
        logic [IW-1:0] rid_v;
        int nwr;
        ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        rst_n = 1'b0; clr = 1'b0;
        awvalid = 1'b0; awid = '0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; arid = '0; arlen = '0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_arready", arready, 1'b1);
        check("rst_awready", awready, 1'b1);
        check("rst_wready", wready, 1'b1);
        check("rst_wr_errs", wr_errs, 0);
        check("rst_rd_errs", rd_errs, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write, ID 2
        bready = 1'b1;
        do_write(2'd2, 1);
        drain("single_wr");
        check("single_wr_errs", wr_errs, 1);

        // Queue fill: four queued, fifth held in the skid buffers
        clear_cnt();
        bready = 1'b0;
        for (int i = 0; i < 5; i++) do_write(ids[i], 4);
        repeat (3) @(posedge clk);
        #1;
        check("qfull_bvalid", bvalid, 1'b1);
        check("qfull_aw_held", awready, 1'b0);
        check("qfull_w_held", wready, 1'b0);
        check("qfull_wr_errs", wr_errs, 0);
        drain("qfull");
        check("qfull_wr_errs_after", wr_errs, 5);

        // Back-to-back bursts without a bubble
        clear_cnt();
        rready = 1'b1;
        r_cyc_q.delete();
        send_ar(2'd1, 3);
        send_ar(2'd3, 0);
        drain("b2b");
        check("b2b_beats", r_cyc_q.size(), 5);
        if (r_cyc_q.size() == 5) check("b2b_span", r_cyc_q[4] - r_cyc_q[0], 4);
        check("b2b_rd_errs", rd_errs, 2);

        // 256-beat burst with RREADY toggling
        clear_cnt();
        rready = 1'b0;
        r_cyc_q.delete();
        rid_v = IW'($urandom);
        send_ar(rid_v, 255);
        for (int n = 0; n < BUDGET && exp_r_q.size() != 0; n++) begin
            @(posedge clk); #1;
            rready = ~rready;
        end
        drain("long");
        check("long_beats", r_cyc_q.size(), 256);
        check("long_rd_errs", rd_errs, 1);
        check("long_rvalid_end", rvalid, 1'b0);

        // Reset mid-burst abandons pending B and remaining R beats
        bready = 1'b0;
        do_write(2'd3, 2);
        rready = 1'b1;
        r_cyc_q.delete();
        send_ar(2'd1, 7);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", rvalid, 1'b0);
        check("mid_rst_arready", arready, 1'b1);
        check("mid_rst_bvalid", bvalid, 1'b0);
        check("mid_rst_beats", r_cyc_q.size(), 2);
        exp_r_q.delete();
        exp_b_q.delete();
        @(negedge clk) rst_n = 1'b1;
        bready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_beats", r_cyc_q.size(), 2);
        check("post_rst_rvalid", rvalid, 1'b0);
        check("post_rst_bvalid", bvalid, 1'b0);
        check("post_rst_rd_errs", rd_errs, 0);

        // Random mixed traffic; 17 reads saturate the 4-bit counter
        nwr = $urandom_range(6, 12);
        wdone = 1'b0;
        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < nwr; i++) do_write(IW'($urandom), $urandom_range(1, 4));
                wdone = 1'b1;
            end
            begin
                for (int i = 0; i < 17; i++) send_ar(IW'($urandom), $urandom_range(0, 5));
                rdone = 1'b1;
            end
            begin
                while (!(wdone && rdone)) begin
                    @(posedge clk); #1;
                    bready = 1'($urandom);
                    rready = 1'($urandom);
                end
            end
        join
        drain("rand");
        check("rand_wr_errs", wr_errs, sat(nwr));
        check("rand_rd_errs_sat", rd_errs, sat(17));

        // Clear wins over a same-cycle RLAST handshake
        rready = 1'b1;
        send_ar(2'd0, 0);
        check("clr_rlast_present", rlast, 1'b1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_rd_errs", rd_errs, 0);
        @(posedge clk); #1;
        check("clr_rd_errs_hold", rd_errs, 0);
        drain("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
